// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and default frame parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE  = 16;
    localparam int MID_SAMPLE  = 7;
    localparam int DEF_NB_DATA = 8;
    localparam int DEF_SB_TICK = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Latency: 2 clocks; no backpressure. Reset value is RST_VAL (idle-high by default).
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], i_d};
        end
    end

    assign o_q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver; defining UART_RX_PARITY_EN adds a parity bit after the data.
// Latency: o_rx_done 1 clock after the i_tick ending the stop bit (plus 2-clock i_rx synchroniser).
// Backpressure: none; o_data and flags hold until the next frame, so each o_rx_done must be taken.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = DEF_NB_DATA,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int S_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int N_W = $clog2(NB_DATA);

    localparam logic [S_W-1:0] S_MID  = S_W'(MID_SAMPLE);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    logic rx_s;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    uart_state_e        state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               ferr_q, ferr_d;
    logic               done_q, done_d;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic par_q, par_d;
    logic perr_q, perr_d;
`else
    // Parity sense has no effect without the parity stage.
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        n_d = '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        data_d  = b_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^b_q) ^ par_q ^ PAR_SENSE;
`endif
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-level serial frames against a frame-level scoreboard; ticks from a local divider.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int NB_DATA    = 8;
    localparam int SB_TICK    = 16;
    localparam int PARITY_ODD = 0;
    localparam int TICK_DIV   = 4;              // shortened divider keeps the run small
    localparam int BIT_CYC    = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 8 + 16 * NB_DATA + 16 + SB_TICK;
`else
    localparam int FRAME_TICKS = 8 + 16 * NB_DATA + SB_TICK;
`endif
    localparam int FRAME_CYC = FRAME_TICKS * TICK_DIV;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_tick = 1'b0;
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_parity_err;

    uart_rx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK), .PARITY_ODD(PARITY_ODD)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err)
    );

    always #10 i_clk = ~i_clk;

    int tick_cnt = 0;
    always @(posedge i_clk) begin
        if (tick_cnt == TICK_DIV - 1) begin
            tick_cnt <= 0;
            i_tick   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1;
            i_tick   <= 1'b0;
        end
    end

    // Every done pulse seen, with the outputs it carried.
    logic [NB_DATA-1:0] cap_data[$];
    logic               cap_ferr[$];
    logic               cap_perr[$];
    int                 multi_pulse = 0;
    logic               prev_done = 1'b0;

    always @(negedge i_clk) begin
        if (o_rx_done === 1'b1) begin
            cap_data.push_back(o_data);
            cap_ferr.push_back(o_frame_err);
            cap_perr.push_back(o_parity_err);
            if (prev_done) multi_pulse++;
        end
        prev_done = (o_rx_done === 1'b1);
    end

    logic [NB_DATA-1:0] exp_data[$];
    logic               exp_ferr[$];
    logic               exp_perr[$];
    logic [NB_DATA-1:0] last_data;
    logic               last_ferr;
    logic               last_perr;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        repeat (BIT_CYC) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [NB_DATA-1:0] d, input logic stop_ok, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < NB_DATA; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
        exp_perr.push_back(((($countones(d) + int'(par_b)) % 2) != 0) ^ (PARITY_ODD != 0));
`else
        exp_perr.push_back(1'b0);
`endif
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            // A bad stop bit is low across its centre only, so the line is idle again before the next check.
            i_rx = 1'b0;
            repeat (BIT_CYC * 3 / 4) @(negedge i_clk);
            i_rx = 1'b1;
            repeat (BIT_CYC / 4) @(negedge i_clk);
        end
        i_rx = 1'b1;
        exp_data.push_back(d);
        exp_ferr.push_back(!stop_ok);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "/count"}, cap_data.size(), exp_data.size());
        while (exp_data.size() > 0 && cap_data.size() > 0) begin
            last_data = exp_data.pop_front();
            last_ferr = exp_ferr.pop_front();
            last_perr = exp_perr.pop_front();
            check({tag, "/data"}, cap_data.pop_front(), last_data);
            check({tag, "/ferr"}, cap_ferr.pop_front(), last_ferr);
            check({tag, "/perr"}, cap_perr.pop_front(), last_perr);
        end
        exp_data.delete(); exp_ferr.delete(); exp_perr.delete();
        cap_data.delete(); cap_ferr.delete(); cap_perr.delete();
        check({tag, "/held_data"}, o_data, last_data);
        check({tag, "/held_ferr"}, o_frame_err, last_ferr);
        check({tag, "/held_perr"}, o_parity_err, last_perr);
    endtask

    logic [NB_DATA-1:0] rd;
    logic               rstop;
    logic               rpar;
    int                 n_brk;

    initial begin
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(negedge i_clk);
        check("rst/data", o_data, 0);
        check("rst/done", o_rx_done, 0);
        check("rst/ferr", o_frame_err, 0);
        check("rst/perr", o_parity_err, 0);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        check_rx("a5");
        repeat (3 * BIT_CYC) @(negedge i_clk);
        check("a5/hold_data", o_data, 8'hA5);
        check("a5/hold_done", o_rx_done, 0);

        i_rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge i_clk);
        check("glitch/no_done", cap_data.size(), 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check_rx("after_glitch");

        send_frame(8'h81, 1'b0, 1'b0);
        check_rx("stop_low");
        repeat (BIT_CYC) @(negedge i_clk);
        send_frame(8'h42, 1'b1, 1'b0);
        check_rx("ferr_clear");

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (BIT_CYC / 2) @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check("midrst/data", o_data, 0);
        check("midrst/done", o_rx_done, 0);
        check("midrst/ferr", o_frame_err, 0);
        check("midrst/perr", o_parity_err, 0);
        @(negedge i_clk);
        repeat (4) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (2 * BIT_CYC) @(negedge i_clk);
        check("midrst/no_done", cap_data.size(), 0);
        check("midrst/data_after", o_data, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_rx("after_rst");

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check_rx("b2b");
        check("b2b/single_pulse", multi_pulse, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        check_rx("par0");
        send_frame(8'h07, 1'b1, 1'b1);
        check_rx("par1");
`endif

        i_rx = 1'b0;
        repeat (FRAME_CYC * 5 / 2) @(negedge i_clk);
        n_brk = cap_data.size();
        check("break/count", n_brk, 2);
        for (int i = 0; i < n_brk; i++) begin
            check("break/data", cap_data[i], 0);
            check("break/ferr", cap_ferr[i], 1);
            check("break/perr", cap_perr[i], (PARITY_ODD != 0) ? 1 : 0);
        end
        i_rx = 1'b1;
        repeat (2 * FRAME_CYC) @(negedge i_clk);
        cap_data.delete(); cap_ferr.delete(); cap_perr.delete();
        send_frame(8'hC3, 1'b1, 1'b0);
        check_rx("after_break");

        for (int k = 0; k < 10; k++) begin
            rd    = NB_DATA'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rpar  = 1'($urandom);
            send_frame(rd, rstop, rpar);
            check_rx("rand");
            if (!rstop) repeat (BIT_CYC) @(negedge i_clk);
            repeat ($urandom_range(0, 40)) @(negedge i_clk);
        end

        check("end/single_pulse", multi_pulse, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
